dsp_mac_sequencer: RTL and testbench

- Controller that runs one DSP slice as a multiply-accumulate engine for dot-product jobs of programmable length.
- Accepts a job on `start`, then streams A/B operand pairs through a valid/ready handshake into the slice.
- Drives the slice's clock enables and OPMODE so that every accepted product is added into P exactly once.
- Presents the final 48-bit P with a valid/ready handshake. It sits between the sample source and the DSP slice instance.

---
 rtl/dsp_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Runs one DSP slice (A1REG=1, MREG=1, PREG=1, pre-adder bypassed) as a
// multiply-accumulate engine for dot-product jobs of programmable length.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   start, len        job request and term count (sampled only in IDLE)
//   busy              high in every state except IDLE
//   in_valid/in_ready operand pair handshake, in_a/in_b operands
//   result*           final 48-bit sum (wired from dsp_P) with handshake
//   dsp_*             slice operands, clock enables and OPMODE; dsp_P back
//   state_dbg         current FSM state for observation
//
// Handshakes: a transfer happens in every cycle where valid && ready are both
// high at the rising edge. Ready never depends on valid; valid, once raised,
// is held with its data until the transfer.
module dsp_mac_sequencer #(
  parameter int LEN_W    = 12,
  parameter int PIPE_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [47:0]      result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [17:0]      dsp_D,
  output logic             dsp_CARRYIN,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CEA,
  output logic             dsp_CEB,
  output logic             dsp_CEM,
  output logic             dsp_CEP,
  output logic             dsp_CECARRYIN,
  input  logic [47:0]      dsp_P,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;

  // Token pipe: one {valid, first, last} entry per cycle, travelling alongside
  // the operand through the A/B and M registers of the slice. The entry at
  // index PIPE_LAT-1 is the token whose product is on M this cycle.
  logic [PIPE_LAT-1:0] tok_valid;
  logic [PIPE_LAT-1:0] tok_first;
  logic [PIPE_LAT-1:0] tok_last;

  logic fire;
  logic is_last;
  logic head_valid;
  logic head_first;
  logic head_last;
  logic p_en;

  assign in_ready   = (state == RUN) && (count < len_q);
  assign fire       = in_valid && in_ready;
  assign is_last    = (count == len_q - 1'b1);

  assign head_valid = tok_valid[PIPE_LAT-1];
  assign head_first = tok_first[PIPE_LAT-1];
  assign head_last  = tok_last[PIPE_LAT-1];

  // P only loads for a real product; in DONE it is frozen so result is stable.
  assign p_en       = head_valid && ((state == RUN) || (state == DRAIN));

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign result       = dsp_P;
  assign state_dbg    = state;

  assign dsp_A         = in_a;
  assign dsp_B         = in_b;
  assign dsp_D         = '0;
  assign dsp_CARRYIN   = 1'b0;
  assign dsp_CECARRYIN = 1'b0;
  assign dsp_CEA       = fire;
  assign dsp_CEB       = fire;
  assign dsp_CEM       = busy;
  assign dsp_CEP       = p_en;
  // X=M always; Z=0 on the first term so a stale P never leaks into a job,
  // Z=P for the rest. Pre-adder, carry and subtract bits stay 0.
  assign dsp_OPMODE    = !p_en     ? 8'h00 :
                         head_first ? 8'h01 : 8'h09;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      len_q     <= '0;
      count     <= '0;
      tok_valid <= '0;
      tok_first <= '0;
      tok_last  <= '0;
    end else begin
      tok_valid[0] <= fire;
      tok_first[0] <= fire && (count == '0);
      tok_last[0]  <= fire && is_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tok_valid[i] <= tok_valid[i-1];
        tok_first[i] <= tok_first[i-1];
        tok_last[i]  <= tok_last[i-1];
      end

      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q <= len;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            count <= count + 1'b1;
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (head_valid && head_last) state <= DONE;
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP slice (A/B, M, P registers,
// DSP48A1-style OPMODE) closes the loop so results are real accumulations.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 12;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [47:0]      result;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic [17:0]      dsp_A, dsp_B, dsp_D;
  logic             dsp_CARRYIN;
  logic [7:0]       dsp_OPMODE;
  logic             dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP, dsp_CECARRYIN;
  logic [47:0]      dsp_P;
  logic [1:0]       state_dbg;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_D(dsp_D), .dsp_CARRYIN(dsp_CARRYIN),
    .dsp_OPMODE(dsp_OPMODE), .dsp_CEA(dsp_CEA), .dsp_CEB(dsp_CEB),
    .dsp_CEM(dsp_CEM), .dsp_CEP(dsp_CEP), .dsp_CECARRYIN(dsp_CECARRYIN),
    .dsp_P(dsp_P), .state_dbg(state_dbg)
  );

  // ---------------- slice model (P deliberately not reset) ----------------
  logic [17:0] sa = '0;
  logic [17:0] sb = '0;
  logic [35:0] sm = '0;
  logic [47:0] sp = 48'h1234_5678_9ABC;
  assign dsp_P = sp;

  always @(posedge CLK) begin
    if (dsp_CEA) sa <= dsp_A;
    if (dsp_CEB) sb <= dsp_B;
    if (dsp_CEM) sm <= 36'(sa) * 36'(sb);
    if (dsp_CEP)
      sp <= ((dsp_OPMODE[1:0] == 2'b01) ? {12'd0, sm} : 48'd0) +
            ((dsp_OPMODE[3:2] == 2'b10) ? sp : 48'd0);
  end

  // ---------------- scoreboard / counters ----------------
  logic [47:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // expected-timing tracker for the per-cycle checks
  logic [1:0]       hp_v = '0;
  logic [1:0]       hp_f = '0;
  int               m_cnt = 0;
  int               m_len = 0;
  logic             m_run = 1'b0;

  logic [17:0] va[8];
  logic [17:0] vb[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: per-cycle checks at the falling edge, then return 1 time unit
  // after the next rising edge, ready for the next stimulus.
  task automatic tick();
    logic fire;
    @(negedge CLK);
    if (RST) begin
      hp_v = '0; hp_f = '0; m_cnt = 0; m_run = 1'b0;
    end else begin
      fire = in_valid && in_ready;
      chk("in_ready", in_ready, m_run);
      chk("cep", dsp_CEP, hp_v[1]);
      chk("opmode", dsp_OPMODE, !hp_v[1] ? 8'h00 : (hp_f[1] ? 8'h01 : 8'h09));
      chk("cea", dsp_CEA, fire);
      chk("ceb", dsp_CEB, fire);
      chk("dsp_ab", {dsp_A, dsp_B}, {in_a, in_b});
      chk("consts", {dsp_D, dsp_CARRYIN, dsp_CECARRYIN}, 0);
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else chk("result", result, exp_q.pop_front());
      end
      hp_v = {hp_v[0], fire};
      hp_f = {hp_f[0], fire && (m_cnt == 0)};
      if (m_run && fire) begin
        m_cnt++;
        if (m_cnt == m_len) m_run = 1'b0;
      end
      if (!busy && start && (len != '0)) begin
        m_run = 1'b1; m_len = int'(len); m_cnt = 0;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Drive one complete job. gap=1 drops in_valid every other cycle; hold is
  // the number of DONE cycles with result_ready low (and start pushed).
  task automatic run_job(input int n, input int gap, input int hold);
    logic [47:0] sum;
    int i, k, last_cyc;
    sum = '0;
    for (int j = 0; j < n; j++) sum += 48'(va[j]) * 48'(vb[j]);
    exp_q.push_back(sum);

    chk("idle_before_start", busy, 0);
    start = 1'b1; len = LEN_W'(n);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);

    i = 0; k = 0; last_cyc = 0;
    while (i < n && k < 200) begin
      in_valid = gap ? (k % 2 == 0) : 1'b1;
      in_a = va[i]; in_b = vb[i];
      #1;
      if (in_valid && in_ready) begin
        i++;
        last_cyc = cyc;
      end
      tick();
      k++;
    end
    if (i < n) chk("fire_timeout", i, n);
    in_valid = 1'b0;

    k = 0;
    while (!result_valid && k < 20) begin tick(); k++; end
    chk("rv_latency", cyc, last_cyc + 3);

    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      start = 1'b1; len = LEN_W'(5);
      #1;
      chk("hold_rv", result_valid, 1);
      chk("hold_result", result, sum);
      chk("hold_cep", dsp_CEP, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_cem", dsp_CEM, 1);
      chk("hold_state", state_dbg, 3);
      tick();
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    chk("idle_after_result", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b1;
    tick(); tick();
    chk("rst_outputs", {busy, in_ready, result_valid, dsp_CEA, dsp_CEB,
                        dsp_CEM, dsp_CEP, dsp_OPMODE}, 0);
    chk("rst_state", state_dbg, 0);
    RST = 1'b0;
    tick();

    // len=4: 1*2+2*2+3*2+4*2 = 20, continuous then with bubbles
    for (int j = 0; j < 4; j++) begin va[j] = 18'(j + 1); vb[j] = 18'd2; end
    run_job(4, 0, 0);
    run_job(4, 1, 0);

    // full-scale operands: 3 * 0xFFFF80001 = 0x2FFFE80003, with a long DONE hold
    for (int j = 0; j < 3; j++) begin va[j] = 18'h3FFFF; vb[j] = 18'h3FFFF; end
    chk("full_scale_model", 48'(va[0]) * 48'(vb[0]) * 3, 48'h2F_FFE8_0003);
    run_job(3, 0, 10);

    // back-to-back: 39 then 49 (not 88)
    va[0] = 18'd3; vb[0] = 18'd5; va[1] = 18'd4; vb[1] = 18'd6;
    run_job(2, 0, 0);
    va[0] = 18'd7; vb[0] = 18'd7;
    run_job(1, 0, 0);

    // random short job with random bubbles
    for (int j = 0; j < 6; j++) begin
      va[j] = 18'($urandom_range(0, 18'h3FFFF));
      vb[j] = 18'($urandom_range(0, 18'h3FFFF));
    end
    run_job(6, 1, 2);

    // reset after 2 of 5 fires
    start = 1'b1; len = LEN_W'(5);
    tick();
    start = 1'b0; in_valid = 1'b1; in_a = 18'd9; in_b = 18'd9;
    tick(); tick();
    RST = 1'b1;
    #1;
    chk("midrst_outputs", {busy, in_ready, result_valid, dsp_CEA, dsp_CEB,
                           dsp_CEM, dsp_CEP, dsp_OPMODE}, 0);
    chk("midrst_state", state_dbg, 0);
    tick();
    RST = 1'b0; in_valid = 1'b0;
    tick();
    va[0] = 18'd2; vb[0] = 18'd3;
    run_job(1, 0, 0);

    // len=0 start is ignored
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_busy_later", busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
